// File: rtl/lsu_memory.sv
// Single-port word memory behind a RISC-V style load/store unit front end.
// Accepts one request per cycle and returns a response after LATENCY cycles, in order.
module lsu_memory #(
  parameter int          ADDR_BITS = 14,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic        i_Write,
  input  logic [31:0] i_Address,
  input  logic [31:0] i_DataIn,
  input  logic [2:0]  i_Mode,
  output logic        o_RspValid,
  output logic        o_RspWrite,
  output logic [31:0] o_DataOut,
  output logic        o_MisalignedAccess,
  output logic        o_BadInstruction,
  output logic        o_AccessFault
);
  localparam int          DEPTH = 1 << ADDR_BITS;
  localparam logic [32:0] SPAN  = 33'(4) << ADDR_BITS;

  logic [31:0]          r_mem [DEPTH];
  logic                 r_vld_p  [LATENCY];
  logic                 r_wr_p   [LATENCY];
  logic [31:0]          r_data_p [LATENCY];
  logic [2:0]           r_err_p  [LATENCY];

  logic                 w_accept;
  logic [31:0]          w_off;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_flt, w_bad, w_mis, w_err;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [31:0]          w_word;
  logic [31:0]          w_rdata;
  logic                 w_out_vld;

  function automatic logic [31:0] extend_load(input logic [2:0] mode, input logic [31:0] word,
                                              input logic [1:0] off);
    logic signed [31:0] sh;
    sh = $signed(word >> {off, 3'b000});
    case (mode)
      3'b000:  extend_load = 32'(signed'(sh[7:0]));
      3'b001:  extend_load = 32'(signed'(sh[15:0]));
      3'b100:  extend_load = {24'b0, sh[7:0]};
      3'b101:  extend_load = {16'b0, sh[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  assign w_accept = i_Valid & i_Reset_n;
  assign w_off    = i_Address - BASE_ADDR;
  assign w_idx    = w_off[ADDR_BITS+1:2];
  assign w_word   = r_mem[w_idx];

  // Request decode: errors are made mutually exclusive by priority fault > bad > misaligned
  always_comb begin
    w_flt   = (i_Address < BASE_ADDR) || ({1'b0, w_off} >= SPAN);
    w_bad   = i_Write ? (i_Mode[2] || i_Mode[1:0] == 2'b11)
                      : (i_Mode == 3'b011 || i_Mode == 3'b110 || i_Mode == 3'b111);
    w_mis   = (i_Mode[1:0] == 2'b01 && w_off[0]) ||
              (i_Mode[1:0] == 2'b10 && w_off[1:0] != 2'b00);
    w_bad   = w_bad & ~w_flt;
    w_mis   = w_mis & ~w_flt & ~w_bad;
    w_err   = w_flt | w_bad | w_mis;
    w_be    = 4'b1111;
    w_wdata = i_DataIn;
    case (i_Mode[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off[1:0];
        w_wdata = {4{i_DataIn[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_DataIn[15:0]}};
      end
      default: ;
    endcase
    w_rdata = (!i_Write && !w_err) ? extend_load(i_Mode, w_word, w_off[1:0]) : 32'b0;
  end

  always_ff @(posedge i_Clock) begin
    if (w_accept && i_Write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  // Stage p0 captures the response at the accept edge; later stages only delay it
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < LATENCY; i++) r_vld_p[i] <= 1'b0;
    end else begin
      r_vld_p[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  always_ff @(posedge i_Clock) begin
    r_wr_p[0]   <= i_Write;
    r_data_p[0] <= w_rdata;
    r_err_p[0]  <= {w_flt, w_bad, w_mis};
    for (int i = 1; i < LATENCY; i++) begin
      r_wr_p[i]   <= r_wr_p[i-1];
      r_data_p[i] <= r_data_p[i-1];
      r_err_p[i]  <= r_err_p[i-1];
    end
  end

  // Response stage: every field is forced to 0 unless a response is actually presented
  assign w_out_vld          = r_vld_p[LATENCY-1] & i_Reset_n;
  assign o_Ready            = i_Reset_n;
  assign o_RspValid         = w_out_vld;
  assign o_RspWrite         = w_out_vld & r_wr_p[LATENCY-1];
  assign o_DataOut          = w_out_vld ? r_data_p[LATENCY-1] : 32'b0;
  assign o_AccessFault      = w_out_vld & r_err_p[LATENCY-1][2];
  assign o_BadInstruction   = w_out_vld & r_err_p[LATENCY-1][1];
  assign o_MisalignedAccess = w_out_vld & r_err_p[LATENCY-1][0];
endmodule

// File: tb/tb_lsu_memory.sv
// Directed bench for lsu_memory: one LATENCY=1 instance at base 0 and one LATENCY=3
// instance at base 0x1000, both with 256-word memories.
module tb_lsu_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        rst1_n, v1, w1, rdy1, rv1, rw1, mis1, bad1, flt1;
  logic [31:0] a1, d1, do1;
  logic [2:0]  m1;
  logic        rst3_n, v3, w3, rdy3, rv3, rw3, mis3, bad3, flt3;
  logic [31:0] a3, d3, do3;
  logic [2:0]  m3;
  logic [31:0] pre [4];

  lsu_memory #(.ADDR_BITS(8), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_l1 (
    .i_Clock(clk), .i_Reset_n(rst1_n), .i_Valid(v1), .o_Ready(rdy1), .i_Write(w1),
    .i_Address(a1), .i_DataIn(d1), .i_Mode(m1), .o_RspValid(rv1), .o_RspWrite(rw1),
    .o_DataOut(do1), .o_MisalignedAccess(mis1), .o_BadInstruction(bad1), .o_AccessFault(flt1));

  lsu_memory #(.ADDR_BITS(8), .LATENCY(3), .BASE_ADDR(32'h0000_1000)) u_l3 (
    .i_Clock(clk), .i_Reset_n(rst3_n), .i_Valid(v3), .o_Ready(rdy3), .i_Write(w3),
    .i_Address(a3), .i_DataIn(d3), .i_Mode(m3), .o_RspValid(rv3), .o_RspWrite(rw3),
    .o_DataOut(do3), .o_MisalignedAccess(mis3), .o_BadInstruction(bad3), .o_AccessFault(flt3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request on the LATENCY=1 instance and check its response one cycle later
  task automatic op1(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] m, input logic [31:0] exp_d, input logic [2:0] exp_f);
    v1 = 1'b1; w1 = w; a1 = a; d1 = d; m1 = m;
    @(negedge clk);
    v1 = 1'b0;
    check({tag, ":vld"},   {31'b0, rv1}, 32'd1);
    check({tag, ":wr"},    {31'b0, rw1}, {31'b0, w});
    check({tag, ":data"},  do1, exp_d);
    check({tag, ":flags"}, {29'b0, flt1, bad1, mis1}, {29'b0, exp_f});
  endtask

  task automatic drv3(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] m);
    v3 = v; w3 = w; a3 = a; d3 = d; m3 = m;
  endtask

  initial begin
    pre[0] = 32'hA0A0_0001; pre[1] = 32'hB1B1_0002;
    pre[2] = 32'hC2C2_0003; pre[3] = 32'hD3D3_0004;
    rst1_n = 1'b0; v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0; m1 = '0;
    rst3_n = 1'b0;
    drv3(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (3) @(negedge clk);
    check("rst:rdy1", {31'b0, rdy1}, 32'd0);
    check("rst:rv1",  {31'b0, rv1},  32'd0);
    check("rst:do1",  do1,           32'd0);
    check("rst:rdy3", {31'b0, rdy3}, 32'd0);

    // LATENCY=1 directed vectors; first request goes in on the first edge out of reset
    rst1_n = 1'b1;
    op1("sw100",   1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0,        3'b000);
    op1("lw100",   1'b0, 32'h100, 32'h0,        3'b010, 32'hDEADBEEF, 3'b000);
    op1("sb101",   1'b1, 32'h101, 32'h0000AB80, 3'b000, 32'h0,        3'b000);
    op1("lb101",   1'b0, 32'h101, 32'h0,        3'b000, 32'hFFFFFF80, 3'b000);
    op1("lbu101",  1'b0, 32'h101, 32'h0,        3'b100, 32'h00000080, 3'b000);
    op1("lw100b",  1'b0, 32'h100, 32'h0,        3'b010, 32'hDEAD80EF, 3'b000);
    op1("lh103",   1'b0, 32'h103, 32'h0,        3'b001, 32'h0,        3'b001);
    op1("sw102",   1'b1, 32'h102, 32'h12345678, 3'b010, 32'h0,        3'b001);
    op1("s011",    1'b1, 32'h100, 32'h12345678, 3'b011, 32'h0,        3'b010);
    op1("lwflt",   1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        3'b100);
    op1("prioflt", 1'b0, 32'h403, 32'h0,        3'b111, 32'h0,        3'b100);
    op1("priobad", 1'b0, 32'h101, 32'h0,        3'b011, 32'h0,        3'b010);
    op1("lw100c",  1'b0, 32'h100, 32'h0,        3'b010, 32'hDEAD80EF, 3'b000);
    op1("lh100",   1'b0, 32'h100, 32'h0,        3'b001, 32'hFFFF80EF, 3'b000);
    op1("sh102",   1'b1, 32'h102, 32'hFFFF1234, 3'b001, 32'h0,        3'b000);
    op1("lhu102",  1'b0, 32'h102, 32'h0,        3'b101, 32'h00001234, 3'b000);
    op1("lb103",   1'b0, 32'h103, 32'h0,        3'b000, 32'h00000012, 3'b000);
    op1("l110",    1'b0, 32'h100, 32'h0,        3'b110, 32'h0,        3'b010);
    op1("lw100d",  1'b0, 32'h100, 32'h0,        3'b010, 32'h123480EF, 3'b000);
    @(negedge clk);
    check("idle:rv1", {31'b0, rv1}, 32'd0);
    check("idle:do1", do1,          32'd0);

    // LATENCY=3: four back-to-back stores, then four back-to-back loads
    rst3_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("st3[%0d]:vld", k), {31'b0, rv3}, (k >= 3) ? 32'd1 : 32'd0);
      if (k >= 3) check($sformatf("st3[%0d]:wr", k), {31'b0, rw3}, 32'd1);
      if (k < 4) drv3(1'b1, 1'b1, 32'h1000 + 32'(4 * k), pre[k], 3'b010);
      else       drv3(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ld3[%0d]:vld", k), {31'b0, rv3}, (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 6) begin
        check($sformatf("ld3[%0d]:data", k), do3, pre[k-3]);
        check($sformatf("ld3[%0d]:wr", k), {31'b0, rw3}, 32'd0);
      end
      if (k < 4) drv3(1'b1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 3'b010);
      else       drv3(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(negedge clk);
    end

    // Below-base access faults on the offset instance
    drv3(1'b1, 1'b0, 32'h0FFC, 32'h0, 3'b010);
    @(negedge clk);
    drv3(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (2) @(negedge clk);
    check("flt3:vld",   {31'b0, rv3}, 32'd1);
    check("flt3:flags", {29'b0, flt3, bad3, mis3}, 32'b100);
    check("flt3:data",  do3, 32'd0);
    @(negedge clk);

    // Two loads in flight, then a one-edge reset drops them
    drv3(1'b1, 1'b0, 32'h1004, 32'h0, 3'b010);
    @(negedge clk);
    drv3(1'b1, 1'b0, 32'h1008, 32'h0, 3'b010);
    @(negedge clk);
    drv3(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    rst3_n = 1'b0;
    #1;
    check("rst3:rdy", {31'b0, rdy3}, 32'd0);
    check("rst3:rv",  {31'b0, rv3},  32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    check("rst3:drop0", {31'b0, rv3}, 32'd0);
    check("rst3:rdy1",  {31'b0, rdy3}, 32'd1);
    drv3(1'b1, 1'b0, 32'h1008, 32'h0, 3'b010);
    @(negedge clk);
    drv3(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    check("rst3:drop1", {31'b0, rv3}, 32'd0);
    @(negedge clk);
    check("rst3:gap", {31'b0, rv3}, 32'd0);
    @(negedge clk);
    check("rst3:vld",  {31'b0, rv3}, 32'd1);
    check("rst3:data", do3, pre[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
